tc_sram_sp_ctrl: RTL and testbench

- Parametrised successor to the fixed 1024x32 technology SRAM wrapper: single-port, byte-masked SRAM with a request/ready handshake, registered read data plus a read-valid strobe, and optional zero-initialisation after reset.
- Out-of-range accesses are flagged and never touch the array.
- Sits between the SoC memory interconnect (core-local RAM, peripheral buffers) and the memory array.
- Contains its own behavioural array.

---
 rtl/tc_sram_sp_ctrl.sv | 77 +++++++
 tb/tb_tc_sram_sp_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tc_sram_sp_ctrl.sv
// tc_sram_sp_ctrl: single-port byte-masked SRAM with request/ready handshake and optional zero-init
module tc_sram_sp_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] mask_i,
  output logic                    ready_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    init_done_o
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, m_addr;
  logic ready_q, ready_d, rvalid_q, rvalid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, m_wdata, bwen_n;
  logic acc, in_range, init_w, cen_n, wen_n;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // macro-style active-low strobes; init owns the port until it finishes
  always_comb begin
    acc = req_i & ready_q;
    in_range = {1'b0, addr_i} < DEPTH_W;
    init_w = state_q == S_INIT;
    state_d = init_w && cnt_q == LAST ? S_RUN : state_q;
    cnt_d = init_w ? cnt_q + 1'b1 : cnt_q;
    ready_d = state_d == S_RUN;
    rvalid_d = acc & ~we_i;
    err_d = acc & ~in_range;
    rdata_d = rvalid_d ? (in_range ? mem[addr_i] : '0) : rdata_q;
    cen_n = ~(init_w | (acc & in_range));
    wen_n = ~(init_w | we_i);
    m_addr = init_w ? cnt_q : addr_i;
    m_wdata = init_w ? '0 : wdata_i;
    bwen_n = '1;
    for (int n = 0; n < NB; n++) bwen_n[8*n +: 8] = {8{~(init_w | mask_i[n])}};
  end

  always_ff @(posedge clk_i)
    if (!cen_n && !wen_n) mem[m_addr] <= (mem[m_addr] & bwen_n) | (m_wdata & ~bwen_n);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT_ZERO ? S_INIT : S_RUN;
      cnt_q <= '0;
      ready_q <= 1'b0;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
      rvalid_q <= rvalid_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready_o = ready_q;
  assign init_done_o = ready_q;
  assign rvalid_o = rvalid_q;
  assign err_o = err_q;
  assign rdata_o = rdata_q;
endmodule

// File: tb/tb_tc_sram_sp_ctrl.sv
// tb_tc_sram_sp_ctrl: random + directed check of two controller configurations against a word-level model
module tb_tc_sram_sp_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [2], req [2], we [2], rdy [2], rv [2], er [2], dn [2];
  logic [3:0] ad [2], mk [2];
  logic [31:0] wd [2], rd [2];
  int vec = 0, mis = 0;
  int thr [2] = '{16, 1};
  int dep [2] = '{16, 12};
  int cnt [2];
  logic [31:0] mm [2][16];
  logic [3:0] kb [2][16];
  logic e_rv [2], e_er [2];
  logic [31:0] e_rd [2], e_kn [2];

  tc_sram_sp_ctrl #(.DEPTH(16), .INIT_ZERO(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(ad[0]),
    .wdata_i(wd[0]), .mask_i(mk[0]), .ready_o(rdy[0]), .rvalid_o(rv[0]),
    .rdata_o(rd[0]), .err_o(er[0]), .init_done_o(dn[0]));
  tc_sram_sp_ctrl #(.DEPTH(12), .ADDR_WIDTH(4), .INIT_ZERO(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(ad[1]),
    .wdata_i(wd[1]), .mask_i(mk[1]), .ready_o(rdy[1]), .rvalid_o(rv[1]),
    .rdata_o(rd[1]), .err_o(er[1]), .init_done_o(dn[1]));

  function automatic logic [31:0] bx(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      mis++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // model: cycles since reset decide readiness; memory tracked per byte with a known mask
  task automatic model();
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        cnt[i] = 0; e_rv[i] = 1'b0; e_er[i] = 1'b0; e_rd[i] = '0; e_kn[i] = '1;
      end else begin
        e_rv[i] = 1'b0; e_er[i] = 1'b0;
        if (req[i] && cnt[i] >= thr[i]) begin
          if (int'(ad[i]) >= dep[i]) begin
            e_er[i] = 1'b1;
            if (!we[i]) begin e_rv[i] = 1'b1; e_rd[i] = '0; e_kn[i] = '1; end
          end else if (we[i]) begin
            for (int b = 0; b < 4; b++) if (mk[i][b]) mm[i][ad[i]][8*b +: 8] = wd[i][8*b +: 8];
            kb[i][ad[i]] = kb[i][ad[i]] | mk[i];
          end else begin
            e_rv[i] = 1'b1; e_rd[i] = mm[i][ad[i]]; e_kn[i] = bx(kb[i][ad[i]]);
          end
        end
        if (cnt[i] < thr[i]) begin
          cnt[i]++;
          if (i == 0 && cnt[i] == thr[i])
            for (int a = 0; a < 16; a++) begin mm[0][a] = '0; kb[0][a] = '1; end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ready[%0d]", i), 32'(rdy[i]), 32'(cnt[i] >= thr[i]));
      chk($sformatf("init_done[%0d]", i), 32'(dn[i]), 32'(cnt[i] >= thr[i]));
      chk($sformatf("rvalid[%0d]", i), 32'(rv[i]), 32'(e_rv[i]));
      chk($sformatf("err[%0d]", i), 32'(er[i]), 32'(e_er[i]));
      chk($sformatf("rdata[%0d]", i), rd[i] & e_kn[i], e_rd[i] & e_kn[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
    check_all();
  endtask

  task automatic acc(input int i, input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    req[i] = 1'b1; we[i] = w; ad[i] = a; wd[i] = d; mk[i] = m;
    step();
    req[i] = 1'b0;
  endtask

  task automatic count_init(input string n);
    int k = 0;
    while (!rdy[0] && k < 40) begin step(); k++; end
    chk(n, 32'(k), 32'd16);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; ad[i] = '0; wd[i] = '0; mk[i] = '0;
      cnt[i] = 0; e_rv[i] = 1'b0; e_er[i] = 1'b0; e_rd[i] = '0; e_kn[i] = '1;
      for (int a = 0; a < 16; a++) begin mm[i][a] = '0; kb[i][a] = '0; end
    end
    repeat (3) step();
    chk("reset_ready_a", 32'(rdy[0]), 32'd0);
    chk("reset_rdata_b", rd[1], 32'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    step();
    chk("b_ready_first", 32'(rdy[1]), 32'd1);
    chk("a_not_ready", 32'(rdy[0]), 32'd0);
    begin
      int k = 1;
      while (!rdy[0] && k < 40) begin step(); k++; end
      chk("init_len", 32'(k), 32'd16);
    end
    for (int a = 0; a < 16; a++) begin
      acc(0, 1'b0, 4'(a), '0, '0);
      chk("init_zero", rd[0], 32'h0);
      chk("init_rv", 32'(rv[0]), 32'd1);
    end
    acc(0, 1'b1, 4'd5, 32'hDEADBEEF, 4'hF);
    acc(0, 1'b1, 4'd5, 32'h11223344, 4'h5);
    acc(0, 1'b0, 4'd5, '0, '0);
    chk("byte_mask", rd[0], 32'hDE22BE44);
    acc(0, 1'b1, 4'd3, 32'hA5A5A5A5, 4'hF);
    chk("wr_no_rv", 32'(rv[0]), 32'd0);
    acc(0, 1'b0, 4'd3, '0, '0);
    chk("b2b_rd1", rd[0], 32'hA5A5A5A5);
    acc(0, 1'b0, 4'd4, '0, '0);
    chk("b2b_rd2", rd[0], 32'h0);
    chk("b2b_rv2", 32'(rv[0]), 32'd1);
    repeat (10) begin
      step();
      chk("hold_rdata", rd[0], 32'h0);
    end
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    repeat (7) step();
    rst[0] = 1'b1; step(); step(); rst[0] = 1'b0;
    count_init("reinit_len");
    acc(1, 1'b1, 4'd11, 32'h12345678, 4'hF);
    acc(1, 1'b1, 4'd13, 32'hFFFFFFFF, 4'hF);
    chk("oor_wr_err", 32'(er[1]), 32'd1);
    chk("oor_wr_rv", 32'(rv[1]), 32'd0);
    step();
    chk("err_pulse", 32'(er[1]), 32'd0);
    acc(1, 1'b0, 4'd13, '0, '0);
    chk("oor_rd_err", 32'(er[1]), 32'd1);
    chk("oor_rd_rv", 32'(rv[1]), 32'd1);
    chk("oor_rd_data", rd[1], 32'h0);
    acc(1, 1'b0, 4'd11, '0, '0);
    chk("inr_err", 32'(er[1]), 32'd0);
    chk("inr_data", rd[1], 32'h12345678);
    acc(1, 1'b0, 4'd11, '0, '0);
    rst[1] = 1'b1;
    #1;
    chk("async_rv", 32'(rv[1]), 32'd0);
    chk("async_rd", rd[1], 32'h0);
    step(); step();
    rst[1] = 1'b0;
    step();
    acc(1, 1'b0, 4'd11, '0, '0);
    chk("persist", rd[1], 32'h12345678);
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i] = $urandom_range(0, 199) == 0;
        req[i] = $urandom_range(0, 3) != 0;
        we[i] = 1'($urandom_range(0, 1));
        ad[i] = 4'($urandom_range(0, 15));
        wd[i] = $urandom;
        mk[i] = 4'($urandom_range(0, 15));
      end
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
